// File: rtl/matmul_pin_driver.sv
// matmul_pin_driver: host-side initiator for the tt_um_matmul pin protocol.
// Takes one 2x2 int8 A/B pair from the command port, shifts the eight
// operand bytes onto the device pins with a load strobe, pulses start, then
// collects eight result bytes and presents C as four 16-bit products.
//
// Ports:
//   clk, rst_n             clock shared with the device, async active-low reset
//   cmd_valid/cmd_ready    operand handshake; cmd_a/cmd_b row-major int8 2x2
//   res_valid/res_ready    result handshake; res_c row-major 16-bit C
//   err_timeout            one-cycle pulse when the device stops responding
//   tt_ena, tt_ui_in,      device-side drives (ena, operand byte,
//   tt_uio_in                {start, load} strobes)
//   tt_uo_out, tt_uio_out  device result byte and result-byte valid
module matmul_pin_driver #(
  parameter int unsigned TIMEOUT       = 255,
  parameter int unsigned RES_VALID_BIT = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_c,
  output logic        err_timeout,
  output logic        tt_ena,
  output logic [7:0]  tt_ui_in,
  output logic [7:0]  tt_uio_in,
  input  logic [7:0]  tt_uo_out,
  input  logic [7:0]  tt_uio_out
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  localparam logic [7:0] LOAD_STROBE = 8'h01;
  localparam logic [7:0] START_PULSE = 8'h02;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;
  localparam logic [2:0] ST_HOLD  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [55:0]      ops_q, ops_d;
  logic [55:0]      rbuf_q, rbuf_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic             cmd_ready_d;
  logic             res_valid_d;
  logic [63:0]      res_c_d;
  logic             err_d;
  logic [7:0]       ui_d;
  logic [7:0]       uio_d;

  logic             byte_valid;
  logic             unused_uio;

  assign byte_valid = tt_uio_out[RES_VALID_BIT];
  // Only the valid bit of uio_out carries meaning for this driver.
  assign unused_uio = ^tt_uio_out;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ops_q       <= '0;
      rbuf_q      <= '0;
      tmo_q       <= '0;
      cmd_ready   <= 1'b0;
      res_valid   <= 1'b0;
      res_c       <= '0;
      err_timeout <= 1'b0;
      tt_ena      <= 1'b0;
      tt_ui_in    <= '0;
      tt_uio_in   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ops_q       <= ops_d;
      rbuf_q      <= rbuf_d;
      tmo_q       <= tmo_d;
      cmd_ready   <= cmd_ready_d;
      res_valid   <= res_valid_d;
      res_c       <= res_c_d;
      err_timeout <= err_d;
      tt_ena      <= 1'b1;
      tt_ui_in    <= ui_d;
      tt_uio_in   <= uio_d;
    end
  end

  // Next state and next values of the registered outputs; pin values are
  // computed one cycle ahead so they appear in the state they belong to.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ops_d       = ops_q;
    rbuf_d      = rbuf_q;
    tmo_d       = tmo_q;
    res_valid_d = res_valid;
    res_c_d     = res_c;
    err_d       = 1'b0;
    ui_d        = 8'h00;
    uio_d       = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          // Byte 0 goes straight to the pins; the other seven queue up.
          ops_d   = {cmd_b, cmd_a[31:8]};
          ui_d    = cmd_a[7:0];
          uio_d   = LOAD_STROBE;
        end
      end

      ST_LOAD: begin
        if (cnt_q == 3'd7) begin
          state_d = ST_START;
          uio_d   = START_PULSE;
        end else begin
          cnt_d = cnt_q + 3'd1;
          ui_d  = ops_q[7:0];
          ops_d = {8'h00, ops_q[55:8]};
          uio_d = LOAD_STROBE;
        end
      end

      ST_START: begin
        state_d = ST_WAIT;
        tmo_d   = '0;
      end

      ST_WAIT: begin
        if (byte_valid) begin
          // Result bytes shift in from the top, low byte first.
          rbuf_d  = {tt_uo_out, rbuf_q[55:8]};
          cnt_d   = 3'd1;
          tmo_d   = '0;
          state_d = ST_READ;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_READ: begin
        if (byte_valid) begin
          tmo_d = '0;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            // Exactly seven bytes were shifted since WAIT, so rbuf holds 0..6.
            state_d     = ST_HOLD;
            res_valid_d = 1'b1;
            res_c_d     = {tt_uo_out, rbuf_q};
          end else begin
            rbuf_d = {tt_uo_out, rbuf_q[55:8]};
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // tt_ena rises on the same edge, so ready implies an enabled device.
    cmd_ready_d = (state_d == ST_IDLE);
  end

endmodule
